tone_gen: RTL and testbench
===========================

Name: tone_gen

Overview:
- Valid-qualified signed 16-bit square-wave source with a programmable period in samples and a programmable amplitude.
- Transmit-side counterpart of the zero-crossing frequency estimator: its output is fed to that estimator, or to the LPC analysis chain, as a known-pitch test and excitation signal.
- Emits one sample per input strobe.
- Counts the upward crossings it generates, so the estimator's count can be checked against this count.

Parameters:
- MIN_PERIOD, 2, smallest period honoured; smaller requested periods are raised to this value.
- CNT_W, 16, width of the emitted-cycle counter.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- v  in  1  sample strobe; each high cycle requests one output sample
- start  in  1  one-cycle pulse; begins generation from IDLE
- stop  in  1  one-cycle pulse; ends generation at the next period boundary
- period  in  16  unsigned period in samples; sampled at start and at each period boundary
- amplitude  in  16  signed magnitude; sampled with period
- x  out  16  signed output sample
- vout  out  1  x valid, one cycle per accepted strobe
- busy  out  1  high in RUN
- cycles  out  CNT_W  number of completed low-to-high transitions, wrapping

Behaviour:
- Reset (synchronous, active-high): x=0, vout=0, busy=0, cycles=0, state=IDLE, phase counter=0, latched period/amplitude=0. Reset mid-run aborts immediately with no further vout.
- States: IDLE, RUN.
- IDLE -> RUN on start.
  - Latch P=max(period,MIN_PERIOD).
  - Latch A=amplitude clamped to 0..32767; negative values become 0.
  - Set phase=0 and clear the stop-pending flag.
- In IDLE, v is ignored: vout stays 0 and x holds its last value.
- RUN, per cycle with v=1:
  - Output sample for phase p: -A if p < floor(P/2), else +A.
  - Register x and pulse vout=1 the following cycle (latency 1).
  - p increments; when p reaches P-1, it wraps to 0.
- RUN with v=0: phase is held and vout=0. Back-to-back strobes give back-to-back samples.
- cycles increments on the registered cycle where a +A sample follows a -A sample, i.e. the sample for p=floor(P/2). It wraps modulo 2^CNT_W.
- If A=0, cycles still increments at each boundary, since a transition is counted by phase, not by value.
- Period boundary (accepted strobe with p=P-1):
  - New period and amplitude are re-latched, taking effect from the next sample.
  - If stop-pending is set, go to IDLE, clear busy in the same cycle as the final vout, and clear stop-pending.
- stop in RUN sets stop-pending. The current period always completes, so every period emitted is whole.
- stop in IDLE has no effect.
- start in RUN is ignored.
- start and stop asserted together in IDLE: start wins, stop is ignored.
- start on the same cycle as an accepted strobe in IDLE: no sample is produced; the first sample comes from the next strobe.
- Changes to period/amplitude mid-period have no effect until the boundary.
- Odd P: the low half is floor(P/2) samples and the high half is ceil(P/2) samples.
- busy=1 from the cycle after start through the cycle the last sample's vout is high.

Optional Feature:
- Macro TONE_GEN_DITHER_EN.
- When defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1 at reset) advances on each accepted strobe in RUN.
  - Its bit 0 selects +1 or -1 LSB, added to the sample before registering.
  - The result saturates to -32767..+32767.
  - cycles counting is unchanged: it is phase based.
- When undefined: no LFSR and exact ±A output.

Test Plan:
- rst, period=8, amplitude=1000, start, v high continuously -> x = -1000 ×4, +1000 ×4, repeating; vout every cycle starting 2 cycles after start; cycles=1 after the 5th vout, 3 after 24 samples.
- period=1, amplitude=500 -> P forced to 2; x alternates -500/+500; cycles increments every 2 samples.
- period=5, amplitude=-200 -> A clamped 0; x=0 throughout; cycles counts 1 per 5 samples; period changed to 4 mid-period -> new length only after the current 5 samples.
- period=6, amplitude=32767, v high every 3rd cycle, stop pulsed after the 2nd sample -> 6 samples total (-32767 ×3, +32767 ×3); busy drops with the last vout; further v ignored.
- Running with period=10, rst asserted after the 7th sample -> next cycle vout=0, x=0, cycles=0, busy=0; start afterwards restarts at phase 0.
- tone_gen output into the zero-crossing estimator (threshold 100), period=20, amplitude=4000, 200 samples -> estimator count equals cycles=10. Under TONE_GEN_DITHER_EN, |x| ∈ {3999, 4001} and the counts still match.

Source files
------------

// File: rtl/tone_gen_if.sv
// tone_gen_if: bundles the sample-strobe, control and output signals of the
// square-wave tone generator.
//   master : drives v/start/stop/period/amplitude, observes x/vout/busy/cycles
//   slave  : the generator itself
// Signals:
//   v          sample strobe, one output sample per high cycle in RUN
//   start      one-cycle pulse, begins generation from IDLE
//   stop       one-cycle pulse, ends generation at the next period boundary
//   period     unsigned period in samples
//   amplitude  signed amplitude (negative values are treated as zero)
//   x          signed output sample
//   vout       x valid
//   busy       generator running
//   cycles     count of generated low-to-high transitions (wrapping)
interface tone_gen_if #(
  parameter int CNT_W = 16
);
  logic                 v;
  logic                 start;
  logic                 stop;
  logic [15:0]          period;
  logic signed [15:0]   amplitude;
  logic signed [15:0]   x;
  logic                 vout;
  logic                 busy;
  logic [CNT_W-1:0]     cycles;

  modport master (
    output v, start, stop, period, amplitude,
    input  x, vout, busy, cycles
  );

  modport slave (
    input  v, start, stop, period, amplitude,
    output x, vout, busy, cycles
  );
endinterface

// File: rtl/tone_gen.sv
// tone_gen: valid-qualified signed 16-bit square-wave source with programmable
// period (in samples) and amplitude. Each accepted strobe in RUN yields one
// registered sample one cycle later. Within a period of P samples the first
// floor(P/2) samples are -A and the remaining ceil(P/2) are +A. The cycles
// counter advances on the sample that starts the +A half, so it can be
// compared against a zero-crossing estimator fed from x.
//
// Ports:
//   clk   system clock
//   rst   synchronous, active-high reset
//   tg    tone_gen_if.slave (v, start, stop, period, amplitude in;
//         x, vout, busy, cycles out)
//
// Parameters:
//   MIN_PERIOD  smallest honoured period; smaller requests are raised to it
//   CNT_W       width of the transition counter
//
// Optional feature macro: TONE_GEN_DITHER_EN
//   When defined, a 16-bit Fibonacci LFSR (taps 16,14,13,11, seed 16'hACE1)
//   adds +/-1 LSB of dither to each sample, saturating to -32767..+32767.
module tone_gen #(
  parameter int MIN_PERIOD = 2,
  parameter int CNT_W      = 16
) (
  input  logic        clk,
  input  logic        rst,
  tone_gen_if.slave   tg
);

  localparam logic [15:0] MIN_P = 16'(MIN_PERIOD);

  typedef enum logic {IDLE, RUN} state_e;

  state_e             state_q, state_d;
  logic [15:0]        phase_q, phase_d;
  logic [15:0]        per_q, per_d;
  logic [14:0]        amp_q, amp_d;
  logic               stopPend_q, stopPend_d;
  logic signed [15:0] x_q, x_d;
  logic               vout_q, vout_d;
  logic               busy_q, busy_d;
  logic [CNT_W-1:0]   cycles_q, cycles_d;

  logic [15:0]        perClamp;
  logic [14:0]        ampClamp;
  logic [15:0]        halfP;
  logic               lowHalf;
  logic               lastPhase;
  logic signed [15:0] ampS;
  logic signed [15:0] rawSample;
  logic signed [15:0] sampleOut;

`ifdef TONE_GEN_DITHER_EN
  logic [15:0]        lfsr_q, lfsr_d;
  logic               lfsrFb;
  logic signed [17:0] dithered;
`endif

  // Values latched at start and at every period boundary.
  assign perClamp = (tg.period < MIN_P) ? MIN_P : tg.period;
  assign ampClamp = tg.amplitude[15] ? 15'd0 : tg.amplitude[14:0];

  assign halfP     = per_q >> 1;
  assign lowHalf   = phase_q < halfP;
  assign lastPhase = phase_q == (per_q - 16'd1);
  assign ampS      = $signed({1'b0, amp_q});
  assign rawSample = lowHalf ? -ampS : ampS;

`ifdef TONE_GEN_DITHER_EN
  // LFSR in right-shift Fibonacci form; bit 0 picks the dither sign.
  assign lfsrFb   = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];
  assign dithered = 18'(rawSample) + (lfsr_q[0] ? 18'sd1 : -18'sd1);

  always_comb begin
    if (dithered > 18'sd32767) begin
      sampleOut = 16'sd32767;
    end else if (dithered < -18'sd32767) begin
      sampleOut = -16'sd32767;
    end else begin
      sampleOut = dithered[15:0];
    end
  end
`else
  assign sampleOut = rawSample;
`endif

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    per_d      = per_q;
    amp_d      = amp_q;
    stopPend_d = stopPend_q;
    x_d        = x_q;
    vout_d     = 1'b0;
    busy_d     = busy_q;
    cycles_d   = cycles_q;
`ifdef TONE_GEN_DITHER_EN
    lfsr_d     = lfsr_q;
`endif
    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (tg.start) begin
          state_d    = RUN;
          per_d      = perClamp;
          amp_d      = ampClamp;
          phase_d    = 16'd0;
          stopPend_d = 1'b0;
          busy_d     = 1'b1;
        end
      end
      RUN: begin
        // busy stays high through the cycle showing the final sample.
        busy_d = 1'b1;
        if (tg.stop) begin
          stopPend_d = 1'b1;
        end
        if (tg.v) begin
          vout_d = 1'b1;
          x_d    = sampleOut;
`ifdef TONE_GEN_DITHER_EN
          lfsr_d = {lfsrFb, lfsr_q[15:1]};
`endif
          // Transition counting is by phase, so A=0 still counts.
          if (phase_q == halfP) begin
            cycles_d = cycles_q + CNT_W'(1);
          end
          if (lastPhase) begin
            phase_d = 16'd0;
            per_d   = perClamp;
            amp_d   = ampClamp;
            if (stopPend_q || tg.stop) begin
              state_d    = IDLE;
              stopPend_d = 1'b0;
            end
          end else begin
            phase_d = phase_q + 16'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      phase_q    <= 16'd0;
      per_q      <= 16'd0;
      amp_q      <= 15'd0;
      stopPend_q <= 1'b0;
      x_q        <= 16'sd0;
      vout_q     <= 1'b0;
      busy_q     <= 1'b0;
      cycles_q   <= '0;
`ifdef TONE_GEN_DITHER_EN
      lfsr_q     <= 16'hACE1;
`endif
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      per_q      <= per_d;
      amp_q      <= amp_d;
      stopPend_q <= stopPend_d;
      x_q        <= x_d;
      vout_q     <= vout_d;
      busy_q     <= busy_d;
      cycles_q   <= cycles_d;
`ifdef TONE_GEN_DITHER_EN
      lfsr_q     <= lfsr_d;
`endif
    end
  end

  assign tg.x      = x_q;
  assign tg.vout   = vout_q;
  assign tg.busy   = busy_q;
  assign tg.cycles = cycles_q;

endmodule

// File: tb/tb_tone_gen.sv
// tb_tone_gen: bench for tone_gen. A period-level model builds the full list
// of samples for each period as soon as that period is latched and pops one
// per accepted strobe; a negedge process compares every output each cycle.
// Directed scenarios add literal expectations on top of the model.
module tb_tone_gen;

  localparam int CNT_W = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tone_gen_if #(.CNT_W(CNT_W)) tg ();

  tone_gen #(.MIN_PERIOD(2), .CNT_W(CNT_W)) dut (
    .clk(clk),
    .rst(rst),
    .tg (tg)
  );

  int nCompared   = 0;
  int nMismatched = 0;
  bit checkEn     = 1'b0;

  typedef struct {
    int val;
    bit up;
  } sample_t;

  sample_t    expQ[$];
  bit         mRun;
  bit         mStopPend;
  int         mP;
  int         mA;
  logic [15:0] expCycles;
  int         expX;
  bit         expVout;
  bit         expBusy;

  int obsX[$];
  int obsCyc[$];

  function automatic int sat(int v);
    if (v > 32767) return 32767;
    if (v < -32767) return -32767;
    return v;
  endfunction

  function automatic bit xMatch(int a, int e);
`ifdef TONE_GEN_DITHER_EN
    return (a == sat(e + 1)) || (a == sat(e - 1));
`else
    return a == e;
`endif
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    nCompared++;
    if (actual != expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic checkX(input string name, input int actual, input int expected);
    nCompared++;
    if (!xMatch(actual, expected)) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  function automatic void latchParams();
    int p;
    int a;
    p  = int'(tg.period);
    a  = int'($signed(tg.amplitude));
    mP = (p < 2) ? 2 : p;
    mA = (a < 0) ? 0 : a;
  endfunction

  function automatic void refill();
    sample_t s;
    expQ.delete();
    for (int i = 0; i < mP; i++) begin
      s.val = (i < mP / 2) ? -mA : mA;
      s.up  = (i == mP / 2);
      expQ.push_back(s);
    end
  endfunction

  // Reference model: outputs expected after each rising edge.
  always @(posedge clk) begin : model
    sample_t s;
    if (rst) begin
      mRun      = 1'b0;
      mStopPend = 1'b0;
      expQ.delete();
      expX      = 0;
      expVout   = 1'b0;
      expBusy   = 1'b0;
      expCycles = '0;
    end else if (!mRun) begin
      expVout = 1'b0;
      expBusy = tg.start;
      if (tg.start) begin
        latchParams();
        mStopPend = 1'b0;
        mRun      = 1'b1;
        refill();
      end
    end else begin
      expBusy = 1'b1;
      if (tg.stop) mStopPend = 1'b1;
      expVout = tg.v;
      if (tg.v) begin
        s    = expQ.pop_front();
        expX = s.val;
        if (s.up) expCycles++;
        if (expQ.size() == 0) begin
          latchParams();
          if (mStopPend) begin
            mRun      = 1'b0;
            mStopPend = 1'b0;
          end else begin
            refill();
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("vout", int'(tg.vout), int'(expVout));
      checkOutput("busy", int'(tg.busy), int'(expBusy));
      checkOutput("cycles", int'(tg.cycles), int'(expCycles));
`ifdef TONE_GEN_DITHER_EN
      if (expVout) checkX("x", int'($signed(tg.x)), expX);
`else
      checkX("x", int'($signed(tg.x)), expX);
`endif
      if (tg.vout) begin
        obsX.push_back(int'($signed(tg.x)));
        obsCyc.push_back(int'(tg.cycles));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input bit iv, input bit istart, input bit istop,
                               input int iper, input int iamp);
    tg.v         = iv;
    tg.start     = istart;
    tg.stop      = istop;
    tg.period    = 16'(iper);
    tg.amplitude = 16'(iamp);
    tick();
  endtask

  task automatic doReset();
    rst = 1'b1;
    applyStimulus(0, 0, 0, 0, 0);
    rst = 1'b0;
    obsX.delete();
    obsCyc.delete();
  endtask

  initial begin
    tg.v = 1'b0; tg.start = 1'b0; tg.stop = 1'b0;
    tg.period = 16'd0; tg.amplitude = 16'sd0;
    doReset();
    checkEn = 1'b1;
    checkOutput("reset_busy", int'(tg.busy), 0);
    checkOutput("reset_cycles", int'(tg.cycles), 0);
    checkOutput("reset_x", int'($signed(tg.x)), 0);

    // Period 8, amplitude 1000, continuous strobes.
    applyStimulus(1, 1, 0, 8, 1000);
    @(negedge clk);
    #1 checkOutput("s1_first_vout_low", int'(tg.vout), 0);
    applyStimulus(1, 0, 0, 8, 1000);
    @(negedge clk);
    #1 checkOutput("s1_second_vout_high", int'(tg.vout), 1);
    for (int i = 0; i < 23; i++) applyStimulus(1, 0, 0, 8, 1000);
    applyStimulus(0, 0, 0, 8, 1000);
    checkOutput("s1_count", obsX.size(), 24);
    if (obsX.size() == 24) begin
      checkX("s1_x0", obsX[0], -1000);
      checkX("s1_x3", obsX[3], -1000);
      checkX("s1_x4", obsX[4], 1000);
      checkX("s1_x8", obsX[8], -1000);
      checkOutput("s1_cyc_at5", obsCyc[4], 1);
      checkOutput("s1_cyc_at4", obsCyc[3], 0);
      checkOutput("s1_cyc_at24", obsCyc[23], 3);
    end

    // Period 1 raised to 2.
    doReset();
    applyStimulus(1, 1, 0, 1, 500);
    for (int i = 0; i < 8; i++) applyStimulus(1, 0, 0, 1, 500);
    applyStimulus(0, 0, 0, 1, 500);
    checkOutput("s2_count", obsX.size(), 8);
    if (obsX.size() == 8) begin
      checkX("s2_x0", obsX[0], -500);
      checkX("s2_x1", obsX[1], 500);
      checkOutput("s2_cyc2", obsCyc[1], 1);
      checkOutput("s2_cyc4", obsCyc[3], 2);
    end

    // Negative amplitude clamps to 0; period change takes effect at boundary.
    doReset();
    applyStimulus(1, 1, 0, 5, -200);
    for (int i = 0; i < 2; i++) applyStimulus(1, 0, 0, 5, -200);
    for (int i = 0; i < 11; i++) applyStimulus(1, 0, 0, 4, -200);
    applyStimulus(0, 0, 0, 4, -200);
    checkOutput("s3_count", obsX.size(), 13);
    if (obsX.size() == 13) begin
      checkX("s3_x0", obsX[0], 0);
      checkOutput("s3_cyc3", obsCyc[2], 1);
      checkOutput("s3_cyc7", obsCyc[6], 1);
      checkOutput("s3_cyc8", obsCyc[7], 2);
      checkOutput("s3_cyc12", obsCyc[11], 3);
    end

    // Sparse strobes with stop after the 2nd sample: exactly one full period.
    doReset();
    applyStimulus(0, 1, 0, 6, 32767);
    for (int i = 0; i < 30; i++) applyStimulus((i % 3) == 0, 0, i == 5, 6, 32767);
    checkOutput("s4_count", obsX.size(), 6);
    if (obsX.size() == 6) begin
      checkX("s4_x2", obsX[2], -32767);
      checkX("s4_x3", obsX[3], 32767);
      checkX("s4_x5", obsX[5], 32767);
    end
    checkOutput("s4_busy_end", int'(tg.busy), 0);

    // Reset in mid-run, then restart from phase 0.
    doReset();
    applyStimulus(1, 1, 0, 10, 1234);
    for (int i = 0; i < 7; i++) applyStimulus(1, 0, 0, 10, 1234);
    rst = 1'b1;
    applyStimulus(1, 0, 0, 10, 1234);
    rst = 1'b0;
    checkOutput("s5_vout", int'(tg.vout), 0);
    checkOutput("s5_x", int'($signed(tg.x)), 0);
    checkOutput("s5_cycles", int'(tg.cycles), 0);
    checkOutput("s5_busy", int'(tg.busy), 0);
    obsX.delete();
    obsCyc.delete();
    applyStimulus(1, 1, 0, 10, 1234);
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 10, 1234);
    applyStimulus(0, 0, 0, 10, 1234);
    checkOutput("s5_restart_count", obsX.size(), 3);
    if (obsX.size() == 3) checkX("s5_restart_x0", obsX[0], -1234);

    // 200 samples at period 20 give 10 transitions.
    doReset();
    applyStimulus(1, 1, 0, 20, 4000);
    for (int i = 0; i < 200; i++) applyStimulus(1, 0, 0, 20, 4000);
    applyStimulus(0, 0, 0, 20, 4000);
    checkOutput("s6_cycles", int'(tg.cycles), 10);

    // Randomized traffic checked by the model.
    doReset();
    for (int i = 0; i < 4000; i++) begin
      int per;
      int amp;
      per = $urandom_range(0, 11);
      case ($urandom_range(0, 4))
        0: amp = -32768;
        1: amp = 32767;
        2: amp = 0;
        3: amp = -int'($urandom_range(1, 1000));
        default: amp = int'($urandom_range(0, 32767));
      endcase
      rst = ($urandom_range(0, 999) < 3);
      applyStimulus($urandom_range(0, 9) < 7, $urandom_range(0, 99) < 6,
                    $urandom_range(0, 99) < 3, per, amp);
    end
    rst = 1'b0;
    applyStimulus(0, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
